// File: rtl/uart_pkg.sv
// Shared state encoding, line levels and sizing helper for the UART TX serializer.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    function automatic int unsigned calc_bytes(input int unsigned width);
        return width / UART_DATA_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side handshake between the TX FIFO and the UART serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             eflag;
    logic [WIDTH-1:0] rdata;
    logic             ren;

    // master: the serializer pulling words; slave: the FIFO read port.
    modport master (input eflag, input rdata, output ren);
    modport slave  (output eflag, output rdata, input ren);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: tick marks the last clock of each UART bit; restart re-aligns it.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic r_clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int unsigned         DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (restart || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign tick = (r_div == DIV_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Pops WIDTH-bit words from the TX FIFO and sends them as BYTES 8N1 frames, LS byte first.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 r_clk,
    input  logic                 reset,
    uart_tx_serializer_if.master fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 word_done
);
    localparam int unsigned             BYTES      = calc_bytes(WIDTH);
    localparam int unsigned             BYTE_CNT_W = $clog2(BYTES) + 1;
    localparam logic [BYTE_CNT_W-1:0]   LAST_BYTE  = BYTE_CNT_W'(BYTES - 1);
    localparam logic [2:0]              LAST_BIT   = 3'(UART_DATA_BITS - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [WIDTH-1:0]      r_shift;
    logic [WIDTH-1:0]      w_shift_nxt;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [BYTE_CNT_W-1:0] w_byte_cnt_nxt;
    logic [2:0]            r_bit_cnt;
    logic [2:0]            w_bit_cnt_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_busy;
    logic                  w_tick;
    logic                  w_restart;

    // Every state change re-aligns the bit period so each START/DATA/STOP entry starts at count 0.
    assign w_restart = (w_state_nxt != r_state);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .r_clk   (r_clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_nxt       = IDLE_LEVEL;
        word_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!fifo.eflag) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_shift_nxt    = fifo.rdata;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = START;
            end
            START: begin
                if (w_tick) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                // Shifting after bit 7 too leaves the next byte's bit 0 at the bottom.
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_byte_cnt < LAST_BYTE) begin
                        w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                        w_state_nxt    = START;
                    end else begin
                        word_done   = 1'b1;
                        w_state_nxt = fifo.eflag ? IDLE : FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Line level is computed for the upcoming state so the registered tx lines up with it.
        case (w_state_nxt)
            START:   w_tx_nxt = START_BIT;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            STOP:    w_tx_nxt = STOP_BIT;
            default: w_tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= IDLE_LEVEL;
            r_busy     <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign fifo.ren = (r_state == FETCH);
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: words queued in a FIFO model, frames decoded off tx and compared in order.
module tb_uart_tx_serializer;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CPB    = 4;
    localparam int unsigned BYTES  = WIDTH / 8;
    localparam int unsigned BUDGET = 3000;

    typedef struct {
        logic [7:0]  data;
        bit          ok;
        int unsigned start_cyc;
    } frame_t;

    logic r_clk = 1'b0;
    logic reset = 1'b1;
    logic tx;
    logic busy;
    logic word_done;

    uart_tx_serializer_if #(.WIDTH(WIDTH)) fifo_if ();

    uart_tx_serializer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .r_clk     (r_clk),
        .reset     (reset),
        .fifo      (fifo_if),
        .tx        (tx),
        .busy      (busy),
        .word_done (word_done)
    );

    int unsigned      cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    logic [WIDTH-1:0] word_q[$];
    logic [7:0]       exp_q[$];
    frame_t           rx_q[$];
    int unsigned      ren_q[$];
    int unsigned      wd_q[$];
    bit               hold_empty = 1'b0;
    int               ren_bad = 0;
    logic             busy_after_wd = 1'b0;
    bit               prev_wd = 1'b0;
    bit               mon_active = 1'b0;
    int unsigned      mon_cnt = 0;
    logic [7:0]       mon_byte = '0;
    bit               mon_ok = 1'b0;
    int unsigned      mon_start = 0;

    always #5 r_clk = ~r_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // FIFO model: rdata valid the cycle after ren; eflag reflects occupancy (or a forced empty).
    always @(posedge r_clk) begin
        cyc <= cyc + 1;
        if (fifo_if.ren && word_q.size() > 0) fifo_if.rdata <= word_q.pop_front();
    end

    always @(negedge r_clk) fifo_if.eflag <= hold_empty || (word_q.size() == 0);

    // Line monitor: logs ren / word_done cycles and decodes 8N1 frames into rx_q.
    always @(negedge r_clk) begin
        prev_wd <= word_done;
        if (prev_wd) busy_after_wd <= busy;
        if (fifo_if.ren === 1'b1) ren_q.push_back(cyc);
        if (word_done === 1'b1) wd_q.push_back(cyc);
        if (fifo_if.ren === 1'b1 && fifo_if.eflag !== 1'b0) ren_bad <= ren_bad + 1;
        if (reset) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
                mon_start  <= cyc;
                mon_ok     <= 1'b1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == CPB - 1 && tx !== 1'b0) mon_ok <= 1'b0;
            if (mon_cnt >= CPB + 1 && mon_cnt <= 8 * CPB + 1 && (mon_cnt % CPB) == 1)
                mon_byte[(mon_cnt - 1) / CPB - 1] <= tx;
            if (mon_cnt == 9 * CPB + 1) begin
                rx_q.push_back('{mon_byte, mon_ok && (tx === 1'b1), mon_start});
                mon_active <= 1'b0;
            end
        end
    end

    task automatic push_word(input logic [WIDTH-1:0] w);
        word_q.push_back(w);
        for (int b = 0; b < BYTES; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        ren_q.delete();
        wd_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_frames(input int unsigned n, output bit timed_out);
        int unsigned k = 0;
        while (rx_q.size() < n && k < BUDGET) begin
            @(posedge r_clk); #1;
            k++;
        end
        timed_out = (rx_q.size() < n);
    endtask

    task automatic wait_idle(output bit timed_out);
        int unsigned k = 0;
        while ((busy !== 1'b0 || word_q.size() > 0) && k < BUDGET) begin
            @(posedge r_clk); #1;
            k++;
        end
        timed_out = (busy !== 1'b0 || word_q.size() > 0);
        repeat (3) @(posedge r_clk);
        #1;
    endtask

    task automatic test_reset();
        bit to;
        push_word(32'h3C5A_96E1);
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (fifo_if.ren !== 1'b0) $display("FAIL reset_ren: got %b want 0", fifo_if.ren); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (word_done !== 1'b0) $display("FAIL reset_word_done: got %b want 0", word_done); else n_pass++;
        @(posedge r_clk); #1;
        reset = 1'b0;
        @(negedge r_clk);
        n_checks++; if (fifo_if.ren !== 1'b0) $display("FAIL reset_release_ren0: got %b want 0", fifo_if.ren); else n_pass++;
        @(negedge r_clk);
        n_checks++; if (fifo_if.ren !== 1'b1) $display("FAIL reset_release_ren1: got %b want 1", fifo_if.ren); else n_pass++;
        wait_frames(BYTES, to);
        n_checks++; if (to) $display("FAIL reset_frames_timeout: got %0d frames want %0d", rx_q.size(), BYTES); else n_pass++;
        for (int i = 0; i < BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL reset_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
        end
        wait_idle(to);
        n_checks++; if (to) $display("FAIL reset_idle_timeout: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_word();
        int unsigned t0;
        bit to;
        clear_logs();
        @(posedge r_clk); #1;
        t0 = cyc;
        push_word(32'hA5C3_0F81);
        wait_frames(BYTES, to);
        n_checks++; if (to) $display("FAIL single_frames_timeout: got %0d frames want %0d", rx_q.size(), BYTES); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL single_idle_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++;
        if (ren_q.size() != 1 || ren_q[0] != t0 + 1)
            $display("FAIL single_ren: got count=%0d first=%0d want count=1 at %0d", ren_q.size(), (ren_q.size() > 0) ? ren_q[0] : 0, t0 + 1);
        else n_pass++;
        for (int i = 0; i < BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL single_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
            n_checks++;
            if (f.start_cyc != t0 + 3 + 10 * CPB * i)
                $display("FAIL single_start[%0d]: got cycle %0d want %0d", i, f.start_cyc, t0 + 3 + 10 * CPB * i);
            else n_pass++;
        end
        n_checks++;
        if (wd_q.size() != 1 || wd_q[0] != t0 + 162)
            $display("FAIL single_word_done: got count=%0d at %0d want count=1 at %0d", wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : 0, t0 + 162);
        else n_pass++;
        n_checks++; if (busy_after_wd !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_after_wd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int unsigned second_start = 0;
        bit to;
        clear_logs();
        @(posedge r_clk); #1;
        push_word(32'h0123_4567);
        push_word(32'h89AB_CDEF);
        wait_frames(2 * BYTES, to);
        n_checks++; if (to) $display("FAIL b2b_frames_timeout: got %0d frames want %0d", rx_q.size(), 2 * BYTES); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL b2b_idle_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++;
        if (ren_q.size() != 2 || wd_q.size() != 2 || ren_q[1] != wd_q[0] + 1)
            $display("FAIL b2b_second_ren: got rens=%0d wds=%0d want 2/2 with ren right after first word_done", ren_q.size(), wd_q.size());
        else n_pass++;
        for (int i = 0; i < 2 * BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            if (i == BYTES) second_start = f.start_cyc;
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL b2b_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
        end
        n_checks++;
        if (wd_q.size() == 0 || second_start != wd_q[0] + 3)
            $display("FAIL b2b_gap: got %0d idle cycles want 2", (wd_q.size() > 0) ? int'(second_start) - int'(wd_q[0]) - 1 : -1);
        else n_pass++;
        n_checks++; if (rx_q.size() != 0) $display("FAIL b2b_extra_frames: got %0d want 0", rx_q.size()); else n_pass++;
    endtask

    task automatic test_empty_hold();
        int bad = 0;
        bit to;
        clear_logs();
        @(posedge r_clk); #1;
        hold_empty = 1'b1;
        push_word(32'hDEAD_BEEF);
        repeat (500) begin
            @(negedge r_clk);
            if (fifo_if.ren !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL empty_hold_activity: got %0d active cycles want 0", bad); else n_pass++;
        n_checks++; if (ren_q.size() != 0) $display("FAIL empty_hold_ren: got %0d rens want 0", ren_q.size()); else n_pass++;
        @(posedge r_clk); #1;
        hold_empty = 1'b0;
        wait_frames(BYTES, to);
        n_checks++; if (to) $display("FAIL empty_release_timeout: got %0d frames want %0d", rx_q.size(), BYTES); else n_pass++;
        for (int i = 0; i < BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL empty_release_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
        end
        wait_idle(to);
        n_checks++; if (to) $display("FAIL empty_idle_timeout: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_eflag_toggle();
        int unsigned t0;
        bit to;
        clear_logs();
        @(posedge r_clk); #1;
        t0 = cyc;
        push_word(32'h5566_7788);
        repeat (45) @(posedge r_clk);
        #1;
        push_word(32'h99AA_BBCC);
        repeat (10) @(posedge r_clk);
        #1;
        hold_empty = 1'b1;
        repeat (10) @(posedge r_clk);
        #1;
        hold_empty = 1'b0;
        wait_frames(2 * BYTES, to);
        n_checks++; if (to) $display("FAIL toggle_frames_timeout: got %0d frames want %0d", rx_q.size(), 2 * BYTES); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL toggle_idle_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++;
        if (ren_q.size() != 2 || wd_q.size() == 0 || ren_q[0] != t0 + 1 || ren_q[1] != wd_q[0] + 1)
            $display("FAIL toggle_ren: got rens=%0d first=%0d want 2 rens, first at %0d, second after word_done", ren_q.size(), (ren_q.size() > 0) ? ren_q[0] : 0, t0 + 1);
        else n_pass++;
        for (int i = 0; i < 2 * BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL toggle_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned t0;
        int unsigned rel;
        bit to;
        clear_logs();
        @(posedge r_clk); #1;
        t0 = cyc;
        push_word(32'h7654_3210);
        repeat (90) @(posedge r_clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL midreset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        // The abandoned bytes 2 and 3 of the interrupted word are never sent.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        push_word(32'hFEDC_BA98);
        repeat (3) @(posedge r_clk);
        #1;
        reset = 1'b0;
        rel = cyc;
        wait_frames(2 + BYTES, to);
        n_checks++; if (to) $display("FAIL midreset_frames_timeout: got %0d frames want %0d", rx_q.size(), 2 + BYTES); else n_pass++;
        wait_idle(to);
        n_checks++; if (to) $display("FAIL midreset_idle_timeout: got busy=%b want 0", busy); else n_pass++;
        n_checks++;
        if (ren_q.size() != 2 || ren_q[1] != rel + 1)
            $display("FAIL midreset_ren: got rens=%0d second=%0d want 2 with second at %0d", ren_q.size(), (ren_q.size() > 1) ? ren_q[1] : 0, rel + 1);
        else n_pass++;
        for (int i = 0; i < 2 + BYTES; i++) begin
            frame_t f;
            logic [7:0] e;
            if (rx_q.size() == 0 || exp_q.size() == 0) break;
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (f.data !== e || !f.ok) $display("FAIL midreset_frame[%0d]: got %02h ok=%0d want %02h ok=1", i, f.data, f.ok, e);
            else n_pass++;
        end
        n_checks++; if (rx_q.size() != 0) $display("FAIL midreset_extra_frames: got %0d want 0", rx_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_empty_hold();
        test_eflag_toggle();
        test_reset_mid_frame();
        n_checks++; if (ren_bad != 0) $display("FAIL ren_while_empty: got %0d occurrences want 0", ren_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
